// File: rtl/spi_daisy_seq_pkg.sv
// Shared definitions for the daisy-chain frame sequencer: FSM state encoding
// and the width helper used to size its counters.
package spi_daisy_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module spi_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/spi_daisy_seq.sv
// Frame sequencer ahead of the SPI master: splits one chain-wide frame into
// back-to-back single-word transfers and reassembles the returned words.
module spi_daisy_seq
  import spi_daisy_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CHAIN_LEN      = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            arstn,
  input  logic                            frame_valid,
  output logic                            frame_ready,
  input  logic [CHAIN_LEN*DATA_WIDTH-1:0] frame_data,
  output logic                            spi_start,
  output logic [DATA_WIDTH-1:0]           data_send,
  input  logic                            spi_done,
  input  logic [DATA_WIDTH-1:0]           data_recv,
  output logic                            resp_valid,
  output logic [CHAIN_LEN*DATA_WIDTH-1:0] resp_data,
  output logic                            resp_err,
  output logic                            busy
);

  localparam int FW = CHAIN_LEN * DATA_WIDTH;
  localparam int KW = cnt_w(CHAIN_LEN);
  localparam int GW = cnt_w(GAP_CYCLES);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);

  // Timers are loaded with n-1 so that expiry lands on the n-th counted cycle.
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] WDT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(CHAIN_LEN - 1);

  state_e                state_q;
  logic [FW-1:0]         tx_q;
  logic [FW-1:0]         rx_q;
  logic [KW-1:0]         k_q;
  logic                  frame_ready_q;
  logic                  spi_start_q;
  logic [DATA_WIDTH-1:0] data_send_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic                  busy_q;

  logic last_word;
  logic gap_load;
  logic gap_exp;
  logic wdt_exp;

  assign last_word = (k_q == K_LAST);
  assign gap_load  = (state_q == ST_WAIT) && spi_done && !last_word;

  spi_seq_timer #(.W(GW)) u_gap_timer (
    .clk      (clk),
    .arstn    (arstn),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (state_q == ST_GAP),
    .expired  (gap_exp)
  );

  spi_seq_timer #(.W(TW)) u_wdt_timer (
    .clk      (clk),
    .arstn    (arstn),
    .load     (state_q == ST_START),
    .load_val (WDT_LOAD),
    .en       (state_q == ST_WAIT),
    .expired  (wdt_exp)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q       <= ST_IDLE;
      tx_q          <= '0;
      rx_q          <= '0;
      k_q           <= '0;
      frame_ready_q <= 1'b1;
      spi_start_q   <= 1'b0;
      data_send_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      spi_start_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_valid) begin
            data_send_q   <= frame_data[FW-1 -: DATA_WIDTH];
            tx_q          <= frame_data << DATA_WIDTH;
            rx_q          <= '0;
            k_q           <= '0;
            spi_start_q   <= 1'b1;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= ST_START;
          end
        end
        ST_START: state_q <= ST_WAIT;
        ST_WAIT: begin
          // A completion on the expiry cycle still wins over the watchdog.
          if (spi_done) begin
            rx_q[(CHAIN_LEN - 1 - int'(k_q)) * DATA_WIDTH +: DATA_WIDTH] <= data_recv;
            if (!last_word) begin
              k_q <= k_q + 1'b1;
              if (GAP_CYCLES == 0) begin
                data_send_q <= tx_q[FW-1 -: DATA_WIDTH];
                tx_q        <= tx_q << DATA_WIDTH;
                spi_start_q <= 1'b1;
                state_q     <= ST_START;
              end else begin
                state_q <= ST_GAP;
              end
            end else begin
              resp_valid_q <= 1'b1;
              state_q      <= ST_DONE;
            end
          end else if (wdt_exp) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_GAP: begin
          if (gap_exp) begin
            data_send_q <= tx_q[FW-1 -: DATA_WIDTH];
            tx_q        <= tx_q << DATA_WIDTH;
            spi_start_q <= 1'b1;
            state_q     <= ST_START;
          end
        end
        ST_DONE: begin
          frame_ready_q <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign frame_ready = frame_ready_q;
  assign spi_start   = spi_start_q;
  assign data_send   = data_send_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = rx_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_daisy_seq.sv
// Directed bench for spi_daisy_seq: one instance with a 4-cycle gap, one with
// no gap, both driven by an inline master model and checked against queues.
module tb_spi_daisy_seq;

  localparam int DW = 8;
  localparam int CL = 2;
  localparam int FW = DW * CL;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arstn;
  logic          sel;
  logic          fv;
  logic [FW-1:0] fd;
  logic          done_d;
  logic [DW-1:0] recv;

  logic          fr0, ss0, rv0, re0, bz0;
  logic          fr1, ss1, rv1, re1, bz1;
  logic [DW-1:0] ds0, ds1;
  logic [FW-1:0] rd0, rd1;

  wire          o_fr = sel ? fr1 : fr0;
  wire          o_ss = sel ? ss1 : ss0;
  wire          o_rv = sel ? rv1 : rv0;
  wire          o_re = sel ? re1 : re0;
  wire          o_bz = sel ? bz1 : bz0;
  wire [DW-1:0] o_ds = sel ? ds1 : ds0;
  wire [FW-1:0] o_rd = sel ? rd1 : rd0;

  spi_daisy_seq #(.DATA_WIDTH(DW), .CHAIN_LEN(CL), .GAP_CYCLES(4), .TIMEOUT_CYCLES(TO)) u_dut0 (
    .clk(clk), .arstn(arstn),
    .frame_valid(fv & ~sel), .frame_ready(fr0), .frame_data(fd),
    .spi_start(ss0), .data_send(ds0),
    .spi_done(done_d & ~sel), .data_recv(recv),
    .resp_valid(rv0), .resp_data(rd0), .resp_err(re0), .busy(bz0)
  );

  spi_daisy_seq #(.DATA_WIDTH(DW), .CHAIN_LEN(CL), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) u_dut1 (
    .clk(clk), .arstn(arstn),
    .frame_valid(fv & sel), .frame_ready(fr1), .frame_data(fd),
    .spi_start(ss1), .data_send(ds1),
    .spi_done(done_d & sel), .data_recv(recv),
    .resp_valid(rv1), .resp_data(rd1), .resp_err(re1), .busy(bz1)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_tx[$];
  logic [FW:0]   exp_resp[$];   // {err, data}

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic offer(input logic [FW-1:0] f, input bit hold, input logic [FW:0] resp);
    int n;
    n = 0;
    while (!o_fr && n < 50) begin
      tick();
      n++;
    end
    chk("ready_before_offer", 16'(o_fr), 16'd1);
    fv = 1'b1;
    fd = f;
    exp_tx.push_back(f[FW-1 -: DW]);
    exp_tx.push_back(f[DW-1:0]);
    exp_resp.push_back(resp);
    tick();
    if (!hold) begin
      fv = 1'b0;
      fd = ~f;
    end
    chk("busy_after_accept", 16'(o_bz), 16'd1);
    chk("ready_low_after_accept", 16'(o_fr), 16'd0);
  endtask

  // Called in the START cycle of a transfer; returns in the next START cycle
  // (non-final word) or in the cycle after the response pulse (final word).
  task automatic xfer(input logic [DW-1:0] r, input int delay, input bit last, input int gap,
                      input bit chain, input logic [FW-1:0] nf, input logic [FW:0] nresp);
    logic [DW-1:0] w;
    logic [FW:0]   er;
    w = exp_tx.pop_front();
    chk("spi_start", 16'(o_ss), 16'd1);
    chk("data_send", 16'(o_ds), 16'(w));
    tick();
    for (int i = 0; i < delay; i++) begin
      chk("start_single_cycle", 16'(o_ss), 16'd0);
      chk("data_send_hold", 16'(o_ds), 16'(w));
      tick();
    end
    done_d = 1'b1;
    recv   = r;
    tick();
    done_d = 1'b0;
    recv   = '0;
    if (last) begin
      er = exp_resp.pop_front();
      chk("resp_valid", 16'(o_rv), 16'd1);
      chk("resp_data", o_rd, er[FW-1:0]);
      chk("resp_err", 16'(o_re), 16'(er[FW]));
      chk("busy_in_resp", 16'(o_bz), 16'd1);
      if (chain) begin
        fd = nf;
        exp_tx.push_back(nf[FW-1 -: DW]);
        exp_tx.push_back(nf[DW-1:0]);
        exp_resp.push_back(nresp);
      end
      tick();
      chk("resp_single_cycle", 16'(o_rv), 16'd0);
      chk("ready_after_resp", 16'(o_fr), 16'd1);
      chk("busy_clear", 16'(o_bz), 16'd0);
      if (chain) begin
        tick();
        chk("b2b_start", 16'(o_ss), 16'd1);
        chk("b2b_busy", 16'(o_bz), 16'd1);
        fv = 1'b0;
        fd = '0;
      end
    end else begin
      for (int i = 0; i < gap; i++) begin
        chk("gap_no_start", 16'(o_ss), 16'd0);
        if (i == 0) begin
          done_d = 1'b1;
          recv   = 8'hEE;
        end
        tick();
        done_d = 1'b0;
        recv   = '0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [DW-1:0] w;
    logic [FW:0]   er;
    arstn = 1'b0; sel = 1'b0; fv = 1'b0; fd = '0; done_d = 1'b0; recv = '0;
    repeat (3) tick();
    chk("rst_frame_ready", 16'(o_fr), 16'd1);
    chk("rst_spi_start", 16'(o_ss), 16'd0);
    chk("rst_data_send", 16'(o_ds), 16'd0);
    chk("rst_resp_valid", 16'(o_rv), 16'd0);
    chk("rst_resp_data", o_rd, 16'd0);
    chk("rst_resp_err", 16'(o_re), 16'd0);
    chk("rst_busy", 16'(o_bz), 16'd0);
    arstn = 1'b1;
    tick();

    // Spurious completion while idle
    done_d = 1'b1; recv = 8'h99;
    tick();
    done_d = 1'b0; recv = '0;
    tick();
    chk("idle_spur_ready", 16'(o_fr), 16'd1);
    chk("idle_spur_busy", 16'(o_bz), 16'd0);
    chk("idle_spur_start", 16'(o_ss), 16'd0);
    chk("idle_spur_resp", 16'(o_rv), 16'd0);
    chk("idle_spur_data", o_rd, 16'd0);

    // Basic frame
    offer(16'hA55A, 1'b0, {1'b0, 16'h3CC3});
    xfer(8'h3C, 3, 1'b0, 4, 1'b0, '0, '0);
    xfer(8'hC3, 1, 1'b1, 4, 1'b0, '0, '0);

    // Back-to-back with frame_valid held
    offer(16'h0102, 1'b1, {1'b0, 16'h1122});
    xfer(8'h11, 2, 1'b0, 4, 1'b0, '0, '0);
    xfer(8'h22, 0, 1'b1, 4, 1'b1, 16'h0304, {1'b0, 16'h3344});
    xfer(8'h33, 1, 1'b0, 4, 1'b0, '0, '0);
    xfer(8'h44, 5, 1'b1, 4, 1'b0, '0, '0);

    // Watchdog timeout on the first word
    offer(16'hBEEF, 1'b0, {1'b1, 16'h0000});
    w = exp_tx.pop_front();
    chk("to_spi_start", 16'(o_ss), 16'd1);
    chk("to_data_send", 16'(o_ds), 16'(w));
    for (int i = 0; i < TO; i++) begin
      tick();
      chk("to_no_resp_yet", 16'(o_rv), 16'd0);
    end
    tick();
    er = exp_resp.pop_front();
    chk("to_resp_valid", 16'(o_rv), 16'd1);
    chk("to_resp_err", 16'(o_re), 16'(er[FW]));
    chk("to_resp_data", o_rd, er[FW-1:0]);
    exp_tx.delete();
    tick();
    chk("to_ready_back", 16'(o_fr), 16'd1);
    chk("to_resp_single", 16'(o_rv), 16'd0);

    // Reset during WAIT of the second word
    offer(16'h1234, 1'b0, {1'b0, 16'h0000});
    xfer(8'h77, 0, 1'b0, 4, 1'b0, '0, '0);
    w = exp_tx.pop_front();
    chk("mid_spi_start", 16'(o_ss), 16'd1);
    chk("mid_data_send", 16'(o_ds), 16'(w));
    tick();
    tick();
    #2 arstn = 1'b0;
    #1;
    chk("arst_frame_ready", 16'(o_fr), 16'd1);
    chk("arst_spi_start", 16'(o_ss), 16'd0);
    chk("arst_data_send", 16'(o_ds), 16'd0);
    chk("arst_resp_valid", 16'(o_rv), 16'd0);
    chk("arst_resp_data", o_rd, 16'd0);
    chk("arst_resp_err", 16'(o_re), 16'd0);
    chk("arst_busy", 16'(o_bz), 16'd0);
    tick();
    tick();
    chk("arst_no_resp", 16'(o_rv), 16'd0);
    arstn = 1'b1;
    exp_tx.delete();
    exp_resp.delete();
    tick();
    chk("post_rst_no_resp", 16'(o_rv), 16'd0);

    offer(16'hFFFF, 1'b0, {1'b0, 16'h5AA5});
    xfer(8'h5A, 2, 1'b0, 4, 1'b0, '0, '0);
    xfer(8'hA5, 0, 1'b1, 4, 1'b0, '0, '0);

    // Zero-gap instance
    sel = 1'b1;
    tick();
    offer(16'h1357, 1'b0, {1'b0, 16'h2468});
    xfer(8'h24, 2, 1'b0, 0, 1'b0, '0, '0);
    xfer(8'h68, 1, 1'b1, 0, 1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
